rca_sum_accumulator: RTL
========================

# rca_sum_accumulator

Downstream consumer for the ripple-carry adder's `s` output. It takes a stream of adder sum words over a valid/ready handshake and accumulates a fixed-length frame of `N` words into a wider register. It then presents the frame total and a sticky overflow flag on a second valid/ready handshake. This block is the first sequential stage after the purely combinational adder datapath.

## Interface
Parameters:
- `IWL`, default 5: width of the incoming sum word; equals the adder's `OWL`.
- `AWL`, default 8: accumulator and output width; must be ≥ `IWL`.
- `N`, default 4: words per frame; must be ≥ 1. Counter width is `$clog2(N)`, minimum 1.

Ports:
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: block can accept a word this cycle.
- `in_data`  in  `IWL`: adder sum word, unsigned.
- `out_valid`  out  1: frame result is valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_sum`  out  `AWL`: frame total, modulo 2^`AWL`.
- `out_ovf`  out  1: at least one carry out of bit `AWL`-1 occurred during the frame.
- `busy`  out  1: high when at least one word of the current frame has been accepted, or while the result is held.

## Operation
- The FSM has two states, ACC and HOLD.
- Reset state is ACC, with `acc`=0, `cnt`=0, `ovf`=0.
- Outputs on reset: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_ovf`=0, `busy`=0.
- ACC state:
  - `in_ready`=1.
  - On accept (`in_valid && in_ready`):
    - `{c, acc}` ← `acc` + zero-extended `in_data`, computed as an (`AWL`+1)-bit sum.
    - `ovf` ← `ovf | c`.
    - `cnt` ← `cnt`+1.
  - When the accepted word is the `N`th (`cnt`==`N`-1), the FSM moves to HOLD and `cnt` ← 0.
  - With no accept, all state holds.
- HOLD state:
  - `in_ready`=0, `out_valid`=1.
  - `out_sum` = `acc` and `out_ovf` = `ovf`; both are stable until the handshake completes.
  - On `out_ready`, the FSM moves to ACC and clears `acc`, `ovf` and `cnt`.
- Arithmetic is unsigned and never saturates. The wrap is reported only through `out_ovf`.
- `busy` = (state==HOLD) || (`cnt`≠0).
- `N`=1 is a degenerate case: every accepted word goes directly to HOLD.

## Timing
- `in_ready`, `out_valid`, `out_sum`, `out_ovf` and `busy` are driven directly from registers. There is no combinational path from any input to any output.
- Latency: `out_valid` rises on the clock edge that accepts the `N`th word and is visible in the following cycle.
- Throughput: one word per cycle in ACC.
- The cycle in which the result handshake completes accepts no input, because `in_ready` is 0 that cycle. The first word of the next frame can be accepted in the cycle immediately after.
- Frame throughput is therefore `N`+1 cycles per frame with no stalls.
- `in_valid` gaps: the accumulator and counter hold, and there is no timeout.
- `in_valid` while in HOLD: the word is not accepted, and upstream must keep it stable.
- Reset asserted mid-frame or during HOLD: the partial frame or pending result is discarded. All outputs take their reset values on the next edge.
- Input values while `rst`=1 are ignored.

## Test plan
- Basic frame (defaults: `IWL`=5, `AWL`=8, `N`=4): feed 0, 30, 21, 15 back-to-back with `out_ready`=1. Expect `out_valid` for exactly one cycle with `out_sum`=66 and `out_ovf`=0, the cycle after the 4th accept. `in_ready` is 0 in that cycle.
- Overflow (`AWL`=6): feed 31, 31, 31, 31. Expect `out_sum`=60 (124 mod 64) and `out_ovf`=1. The next frame of 1, 2, 3, 4 gives `out_sum`=10 and `out_ovf`=0, showing the sticky flag is cleared.
- Output backpressure: complete a frame with `out_ready`=0 for 5 cycles while `in_valid`=1 with data 7. Expect `in_ready`=0 and `out_sum`/`out_ovf`/`out_valid` stable throughout. Raise `out_ready`: the result drops the following cycle, and the held word 7 is accepted as the first word of the new frame.
- Input gaps: feed 5, idle 3 cycles, 6, idle 1 cycle, 7, 8. Expect `out_sum`=26, `busy`=1 from the first accept onward, and no early `out_valid`.
- Reset mid-frame: accept 10 and 20, pulse `rst` for one cycle, then feed 1, 1, 1, 1. Expect `out_sum`=4, and `busy`=0 in the cycle after reset.
- Adder-driven frame: connect the adder with operand pairs (0,0), (15,15), (14,7), (10,5). The sums are 0, 30, 21, 15, so expect `out_sum`=66 and `out_ovf`=0.

Source files
------------

// File: rtl/rca_sum_accumulator.sv
// rtl/rca_sum_accumulator.sv - accumulates N adder sum words per frame and presents the total with a sticky overflow flag
module rca_sum_accumulator #(
  parameter int IWL = 5,
  parameter int AWL = 8,
  parameter int N   = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IWL-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [AWL-1:0] out_sum,
  output logic           out_ovf,
  output logic           busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {ACC, HOLD} state_e;

  state_e         state_q, state_d;
  logic [AWL-1:0] acc_q, acc_d;
  logic           ovf_q, ovf_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AWL:0]   sum_w;

  // One extra bit captures the carry out of the accumulator MSB.
  assign sum_w = {1'b0, acc_q} + {{(AWL + 1 - IWL){1'b0}}, in_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d = sum_w[AWL-1:0];
          ovf_d = ovf_q | sum_w[AWL];
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACC;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // All outputs decode registered state only; no input reaches an output.
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign busy      = (state_q == HOLD) || (cnt_q != '0);

endmodule
